// File: rtl/ch_avg_par_if.sv
// Sample/result bundle for the I/Q channel-estimate averager.
// The master drives samples and control; the slave returns averaged results.
interface ch_avg_par_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int IDX_W = 8
) ();
  logic signed [IN_W-1:0]  in_i;
  logic signed [IN_W-1:0]  in_q;
  logic                    in_vld;
  logic [1:0]              avg_mode;
  logic                    sym_start;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_vld;
  logic [IDX_W-1:0]        out_idx;
  logic                    sat_flag;
  logic                    drop_flag;

  modport master (
    output in_i, in_q, in_vld, avg_mode, sym_start,
    input  out_i, out_q, out_vld, out_idx, sat_flag, drop_flag
  );

  modport slave (
    input  in_i, in_q, in_vld, avg_mode, sym_start,
    output out_i, out_q, out_vld, out_idx, sat_flag, drop_flag
  );
endinterface

// File: rtl/ch_avg_par.sv
// Groups 1..4 consecutive I/Q samples, averages each group with half-up
// rounding, saturates to OUT_W and emits one result two cycles after close.
module ch_avg_par #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 15,
  parameter int IDX_W  = 8
) (
  input logic         clk,
  input logic         rst,
  ch_avg_par_if.slave bus
);
  localparam int SW = IN_W + 2;
  localparam int DW = SW + 1;
  localparam int PW = SW + FRAC_W + 2;

  localparam logic signed [PW-1:0] RECIP = PW'((2 ** (FRAC_W + 1) + 3) / 6);
  localparam logic signed [PW-1:0] HALF  = PW'(2 ** (FRAC_W - 1));
  localparam logic signed [DW-1:0] ONE   = DW'(1);
  localparam logic signed [DW-1:0] TWO   = DW'(2);
  localparam logic signed [DW-1:0] MAX_V = DW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] MIN_V = -MAX_V - ONE;

  typedef struct packed {
    logic                    clip;
    logic signed [OUT_W-1:0] val;
  } sat_t;

  logic signed [SW-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [1:0]              cnt_q, cnt_d, mode_q, mode_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [SW-1:0]    s1_i_q, s1_i_d, s1_q_q, s1_q_d;
  logic [1:0]              s1_mode_q, s1_mode_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
  logic signed [OUT_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic                    out_vld_q, out_vld_d, sat_q, sat_d, drop_q, drop_d;

  logic signed [SW-1:0]    base_i, base_q, sum_i, sum_q;
  logic [1:0]              base_cnt, grp_mode;
  logic [IDX_W-1:0]        base_idx;
  sat_t                    res_i, res_q;

  function automatic logic signed [DW-1:0] div_n(input logic signed [SW-1:0] s,
                                                 input logic [1:0] m);
    logic signed [DW-1:0] e;
    logic signed [PW-1:0] p;
    e = DW'(s);
    p = PW'(s) * RECIP + HALF;
    case (m)
      2'd0:    div_n = e;
      2'd1:    div_n = (e + ONE) >>> 1;
      2'd2:    div_n = DW'(p >>> FRAC_W);
      default: div_n = (e + TWO) >>> 2;
    endcase
  endfunction

  // The N=3 reciprocal lands one LSB below a full-scale negative average;
  // that lands on the rail and is not reported as a clip.
  function automatic sat_t saturate(input logic signed [DW-1:0] v, input logic n3);
    sat_t r;
    r.clip = 1'b0;
    r.val  = OUT_W'(v);
    if (v > MAX_V) begin
      r.clip = 1'b1;
      r.val  = OUT_W'(MAX_V);
    end else if (v < MIN_V) begin
      r.clip = !(n3 && (v == MIN_V - ONE));
      r.val  = OUT_W'(MIN_V);
    end
    return r;
  endfunction

  // Stage 0: grouping, accumulation and close detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    s1_vld_d  = 1'b0;
    s1_i_d    = s1_i_q;
    s1_q_d    = s1_q_q;
    s1_mode_d = s1_mode_q;
    s1_idx_d  = s1_idx_q;
    drop_d    = 1'b0;
    base_i    = acc_i_q;
    base_q    = acc_q_q;
    base_cnt  = cnt_q;
    base_idx  = idx_q;
    if (bus.sym_start) begin
      drop_d   = (cnt_q != 2'd0);
      base_i   = '0;
      base_q   = '0;
      base_cnt = 2'd0;
      base_idx = '0;
      acc_i_d  = '0;
      acc_q_d  = '0;
      cnt_d    = 2'd0;
      idx_d    = '0;
    end
    grp_mode = (base_cnt == 2'd0) ? bus.avg_mode : mode_q;
    sum_i    = base_i + {{2{bus.in_i[IN_W-1]}}, bus.in_i};
    sum_q    = base_q + {{2{bus.in_q[IN_W-1]}}, bus.in_q};
    if (bus.in_vld) begin
      mode_d = grp_mode;
      if (base_cnt == grp_mode) begin
        s1_vld_d  = 1'b1;
        s1_i_d    = sum_i;
        s1_q_d    = sum_q;
        s1_mode_d = grp_mode;
        s1_idx_d  = base_idx;
        acc_i_d   = '0;
        acc_q_d   = '0;
        cnt_d     = 2'd0;
        idx_d     = base_idx + IDX_W'(1);
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = base_cnt + 2'd1;
      end
    end
  end

  // Stage 2: divide, saturate and update the held outputs only on a result.
  always_comb begin
    res_i     = saturate(div_n(s1_i_q, s1_mode_q), s1_mode_q == 2'd2);
    res_q     = saturate(div_n(s1_q_q, s1_mode_q), s1_mode_q == 2'd2);
    out_vld_d = s1_vld_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    out_idx_d = out_idx_q;
    sat_d     = sat_q;
    if (s1_vld_q) begin
      out_i_d   = res_i.val;
      out_q_d   = res_q.val;
      out_idx_d = s1_idx_q;
      sat_d     = res_i.clip | res_q.clip;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_i_q    <= '0;
      s1_q_q    <= '0;
      s1_mode_q <= '0;
      s1_idx_q  <= '0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      out_idx_q <= '0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values.
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_i_q    <= s1_i_d;
      s1_q_q    <= s1_q_d;
      s1_mode_q <= s1_mode_d;
      s1_idx_q  <= s1_idx_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      out_idx_q <= out_idx_d;
      out_vld_q <= out_vld_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.sat_flag  = sat_q;
  assign bus.drop_flag = drop_q;
endmodule

// File: doc/ch_avg_par.md
CH_AVG_PAR -- requirements
Module: ch_avg_par

Interface
REQ-001 SHALL have parameter IN_W, default 16: signed width of each I/Q input sample.
REQ-002 SHALL have parameter OUT_W, default 16: signed width of each averaged I/Q output, with OUT_W <= IN_W+2.
REQ-003 SHALL have parameter FRAC_W, default 15: fractional bits of the divide-by-3 reciprocal constant.
REQ-004 SHALL have parameter IDX_W, default 8: width of the group index counter.
REQ-005 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port in_i, input, IN_W: signed in-phase channel-estimate sample.
REQ-008 SHALL have port in_q, input, IN_W: signed quadrature channel-estimate sample.
REQ-009 SHALL have port in_vld, input, 1: in_i and in_q are valid this cycle.
REQ-010 SHALL have port avg_mode, input, 2: group length N minus 1 (0->N=1, 1->2, 2->3, 3->4).
REQ-011 SHALL have port sym_start, input, 1: restart grouping and clear the index.
REQ-012 SHALL have port out_i, output, OUT_W: signed averaged I.
REQ-013 SHALL have port out_q, output, OUT_W: signed averaged Q.
REQ-014 SHALL have port out_vld, output, 1: one-cycle pulse marking out_i, out_q, out_idx and sat_flag valid.
REQ-015 SHALL have port out_idx, output, IDX_W: index of the emitted group since the last sym_start.
REQ-016 SHALL have port sat_flag, output, 1: the emitted I or Q was clipped; qualified by out_vld.
REQ-017 SHALL have port drop_flag, output, 1: one-cycle pulse when a partial group is discarded.

Function
REQ-018 SHALL latch avg_mode on the first valid sample of each group and hold it for that group, ignoring avg_mode changes mid-group.
REQ-019 SHALL accumulate I and Q separately in signed IN_W+2-bit accumulators, with no overflow possible for N<=4.
REQ-020 SHALL track each group with a sample counter running 0..N-1; the in_vld cycle at count N-1 closes the group.
REQ-021 SHALL, on group close, register the full sum (including the closing sample) into a stage-1 register and clear the accumulator and counter in the same cycle.
REQ-022 SHALL accept back-to-back groups at one sample per cycle with no bubble.
REQ-023 SHALL, in stage 2, divide by N: N=1 pass-through; N=2 (sum+1)>>>1; N=4 (sum+2)>>>2; N=3 (sum*round(2^FRAC_W/3) + 2^(FRAC_W-1))>>>FRAC_W, with 10923 at FRAC_W=15.
REQ-024 SHALL use arithmetic shifts so that rounding is half-up toward +infinity.
REQ-025 SHALL saturate each divided result to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat_flag when either I or Q clips.
REQ-026 SHALL register out_i, out_q, out_idx and sat_flag, and pulse out_vld exactly 2 cycles after the closing in_vld.
REQ-027 SHALL hold out_i, out_q, out_idx and sat_flag at their last values while out_vld is low.
REQ-028 SHALL increment out_idx by 1 per emitted group and wrap from 2^IDX_W-1 to 0.
REQ-029 SHALL, on sym_start with a partial group pending (count>0), discard the partial sums and pulse drop_flag in the next cycle.
REQ-030 SHALL, on sym_start together with in_vld, take that sample as the first of a new group, latch avg_mode from it, and restart the index so that this group emits out_idx=0.
REQ-031 SHALL, on sym_start without in_vld, make the next valid sample the first of a new group.
REQ-032 SHALL let a group already in stage 1 or stage 2 complete unaffected by sym_start, emitting with its original index.
REQ-033 SHALL, in mode N=1, emit every sample, so sym_start never causes a drop.
REQ-034 SHALL stall the counter and accumulators on in_vld=0 cycles, with no timeout.

Reset
REQ-035 SHALL, when rst=0, asynchronously clear the accumulators, counter, latched mode, pipeline registers, out_i, out_q, out_idx, sat_flag, out_vld and drop_flag to 0.
REQ-036 SHALL, on reset assertion mid-group or mid-pipeline, discard all pending data with no out_vld or drop_flag afterward.
REQ-037 SHALL, after rst deassertion, treat the first valid sample as the first of a group with out_idx=0.

Verification
REQ-038 Bench SHALL cover: mode 2, I=3,6,9 and Q=-3,-6,-9 on consecutive cycles -> out_i=6, out_q=-6, out_idx=0, out_vld 2 cycles after the third sample, sat_flag=0.
REQ-039 Bench SHALL cover rounding: mode 1, I=1,2 -> 2; mode 1, I=-1,-2 -> -1; mode 2, I=1,1,2 -> 1; mode 3, I=1,1,1,2 -> 1.
REQ-040 Bench SHALL cover saturation: IN_W=OUT_W=16, mode 2, I=32767 three times -> out_i=32767, sat_flag=1; I=-32768 three times -> -32768, sat_flag=0.
REQ-041 Bench SHALL cover partial drop: mode 3 with 2 samples, then sym_start+in_vld -> drop_flag pulse, no out_vld for the partial, next group emits out_idx=0.
REQ-042 Bench SHALL cover mode change and throughput: avg_mode changed 1->3 after the first sample of a mode-1 group -> that group still averages 2 samples; 12 continuous mode-0 samples -> 12 out_vld pulses, out_idx 0..11.
REQ-043 Bench SHALL cover reset mid-pipeline: rst=0 one cycle after a group closes -> no out_vld; index restarts at 0 after release.
